// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch controller feeding a UART transmitter.
// Bytes queue at up to one per clock. They are handed over one at a time:
// an en pulse carries the byte to the transmitter, and the next launch waits
// for the transmitter's busy flag to rise and then fall. An optional number
// of idle clocks can be inserted between bytes.
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   fifo_cnt,
    output logic              overflow,
    output logic              uart_tx_en,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_busy,
    output logic              send_done
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    // The gap counter runs 0 .. GAP_CYCLES-1, so log2(GAP_CYCLES) bits suffice.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_cnt;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic [1:0]        r_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_tx_en;
    logic [7:0]        r_tx_data;
    logic              r_send_done;

    logic              w_push;
    logic              w_pop;
    logic [ADDR_W:0]   w_cnt_next;

    // A pop only happens from IDLE with data present and the transmitter free.
    assign w_push     = wr_en && !r_full;
    assign w_pop      = (r_state == S_IDLE) && !r_empty && !uart_tx_busy;
    assign w_cnt_next = r_cnt + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);

    assign full         = r_full;
    assign empty        = r_empty;
    assign fifo_cnt     = r_cnt;
    assign overflow     = r_overflow;
    assign uart_tx_en   = r_tx_en;
    assign uart_tx_data = r_tx_data;
    assign send_done    = r_send_done;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and flags; full/empty are derived from the next count
    // so they are registered yet exact every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            r_cnt   <= w_cnt_next;
            r_full  <= (w_cnt_next == DEPTH_CNT);
            r_empty <= (w_cnt_next == '0);
        end
    end

    // Launch controller: en and send_done are single-cycle pulses, data holds
    // its value until the next launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gap_cnt   <= '0;
            r_tx_en     <= 1'b0;
            r_tx_data   <= 8'h00;
            r_send_done <= 1'b0;
        end else begin
            r_tx_en     <= 1'b0;
            r_send_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rd_ptr];
                        r_tx_en   <= 1'b1;
                        r_state   <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        r_send_done <= 1'b1;
                        if (GAP_CYCLES > 0) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural transmitter and serial decoder
// surround the DUT; a queue-based reference model predicts every output.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int GAP    = 10;
    localparam int CPB    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   fifo_cnt;
    logic              overflow;
    logic              uart_tx_en;
    logic [7:0]        uart_tx_data;
    logic              send_done;

    logic              tx_busy;
    logic              tx_line;
    logic [9:0]        tx_shift;
    int                tx_bit;
    int                tx_tick;

    logic              rx_active;
    int                rx_cnt;
    logic [7:0]        rx_byte;
    int                rx_q[$];

    int                n_checks = 0;
    int                n_pass = 0;

    logic [7:0]        q[$];
    logic              m_ovf = 1'b0;
    int                m_phase = 0;
    int                m_allow = 0;
    int                cyc = 0;
    logic              exp_en = 1'b0;
    logic              exp_done = 1'b0;
    logic [7:0]        exp_data = 8'h00;

    int                launched_q[$];
    int                en_cnt = 0;
    int                done_cnt = 0;
    int                last_done_cyc = -1;
    int                gap_meas = -1;
    int                peak_cnt = 0;
    int                exp_peak = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .fifo_cnt     (fifo_cnt),
        .overflow     (overflow),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (tx_busy),
        .send_done    (send_done)
    );

    // Transmitter model: samples en, raises busy next cycle, sends 8N1 LSB first.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx_line  <= 1'b1;
            tx_shift <= '0;
            tx_bit   <= 0;
            tx_tick  <= 0;
        end else if (!tx_busy) begin
            if (uart_tx_en) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, uart_tx_data, 1'b0};
                tx_line  <= 1'b0;
                tx_bit   <= 0;
                tx_tick  <= 0;
            end
        end else begin
            if (tx_tick == CPB - 1) begin
                tx_tick <= 0;
                if (tx_bit == 9) begin
                    tx_busy <= 1'b0;
                    tx_line <= 1'b1;
                end else begin
                    tx_bit  <= tx_bit + 1;
                    tx_line <= tx_shift[tx_bit + 1];
                end
            end else begin
                tx_tick <= tx_tick + 1;
            end
        end
    end

    // Serial decoder: mid-bit sampling of the line; a bad stop bit records -1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_active <= 1'b0;
            rx_cnt    <= 0;
            rx_byte   <= '0;
        end else if (!rx_active) begin
            if (!tx_line) begin
                rx_active <= 1'b1;
                rx_cnt    <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % CPB == CPB / 2) begin
                if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
                    rx_byte[rx_cnt / CPB - 1] <= tx_line;
                end else if (rx_cnt / CPB == 9) begin
                    rx_active <= 1'b0;
                    if (tx_line) rx_q.push_back(int'(rx_byte));
                    else rx_q.push_back(-1);
                end
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model step for one clock edge, using pre-edge inputs.
    // Launch eligibility is tracked as the earliest edge a pop may happen.
    task automatic model_step();
        bit pop;
        pop = (m_phase == 0) && (cyc >= m_allow) && (q.size() > 0) && !tx_busy;
        exp_en   = pop;
        exp_done = 1'b0;
        if (m_phase == 1) begin
            if (tx_busy) m_phase = 2;
        end else if (m_phase == 2) begin
            if (!tx_busy) begin
                exp_done = 1'b1;
                m_phase  = 0;
                m_allow  = cyc + GAP + 1;
            end
        end
        if (pop) begin
            exp_data = q[0];
            m_phase  = 1;
        end
        if (wr_en) begin
            if (q.size() < DEPTH) q.push_back(wr_data);
            else m_ovf = 1'b1;
        end
        if (pop) void'(q.pop_front());
        cyc++;
        if (q.size() > exp_peak) exp_peak = q.size();
    endtask

    task automatic check_outputs();
        chk("fifo_cnt", int'(fifo_cnt), q.size());
        chk("full", int'(full), int'(q.size() == DEPTH));
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("tx_en", int'(uart_tx_en), int'(exp_en));
        chk("send_done", int'(send_done), int'(exp_done));
        chk("tx_data", int'(uart_tx_data), int'(exp_data));
        if (int'(fifo_cnt) > peak_cnt) peak_cnt = int'(fifo_cnt);
        if (uart_tx_en) begin
            en_cnt++;
            launched_q.push_back(int'(uart_tx_data));
            if (last_done_cyc >= 0) gap_meas = cyc - last_done_cyc;
            $display("launch #%0d data 0x%02h at edge %0d", en_cnt, uart_tx_data, cyc - 1);
        end
        if (send_done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic tick(input logic wr, input logic [7:0] d);
        wr_en   = wr;
        wr_data = d;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_cnt"}, int'(fifo_cnt), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_en"}, int'(uart_tx_en), 0);
        chk({tag, "_data"}, int'(uart_tx_data), 0);
        chk({tag, "_done"}, int'(send_done), 0);
    endtask

    task automatic clear_phase();
        launched_q.delete();
        rx_q.delete();
        en_cnt = 0;
        done_cnt = 0;
        last_done_cyc = -1;
        gap_meas = -1;
        peak_cnt = 0;
        exp_peak = q.size();
    endtask

    // Asynchronous reset applied between edges; model returns to its reset state.
    task automatic do_reset(input string tag);
        wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        q.delete();
        m_ovf    = 1'b0;
        m_phase  = 0;
        m_allow  = 0;
        exp_en   = 1'b0;
        exp_done = 1'b0;
        exp_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_phase();
    endtask

    // Drain everything, then compare what the serial line carried with launches.
    task automatic drain_and_compare(input string tag);
        int n;
        n = 0;
        while (!(q.size() == 0 && m_phase == 0 && !tx_busy && !rx_active && cyc >= m_allow) && n < 5000) begin
            tick(1'b0, 8'h00);
            n++;
        end
        if (n >= 5000) chk({tag, "_drain_timeout"}, 0, 1);
        chk({tag, "_rx_count"}, rx_q.size(), launched_q.size());
        for (int i = 0; i < rx_q.size() && i < launched_q.size(); i++) begin
            chk({tag, "_rx_byte"}, rx_q[i], launched_q[i]);
        end
    endtask

    initial begin
        int n;
        int aa_seen;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst0");
        rst_n = 1'b1;
        clear_phase();

        // Single byte 0x55.
        tick(1'b1, 8'h55);
        drain_and_compare("t1");
        chk("t1_launches", launched_q.size(), 1);
        if (launched_q.size() > 0) chk("t1_byte", launched_q[0], 8'h55);
        chk("t1_done", done_cnt, 1);
        clear_phase();

        // Burst of 0x01..0x10 on consecutive cycles.
        for (int i = 1; i <= 16; i++) tick(1'b1, 8'(i));
        chk("t2_peak", peak_cnt, exp_peak);
        drain_and_compare("t2");
        chk("t2_launches", launched_q.size(), 16);
        for (int i = 0; i < launched_q.size(); i++) chk("t2_order", launched_q[i], i + 1);
        chk("t2_done", done_cnt, 16);
        chk("t2_empty", int'(empty), 1);
        clear_phase();

        // Fill to full, then push 0xAA while full.
        for (int i = 0; i < 17; i++) tick(1'b1, 8'(8'h30 + i));
        chk("t3_full", int'(full), 1);
        chk("t3_cnt_full", int'(fifo_cnt), DEPTH);
        tick(1'b1, 8'hAA);
        chk("t3_ovf", int'(overflow), 1);
        chk("t3_cnt_same", int'(fifo_cnt), DEPTH);
        drain_and_compare("t3");
        chk("t3_ovf_sticky", int'(overflow), 1);
        aa_seen = 0;
        foreach (launched_q[i]) if (launched_q[i] == 8'hAA) aa_seen++;
        chk("t3_no_aa", aa_seen, 0);
        chk("t3_launches", launched_q.size(), 17);
        clear_phase();

        // Push and pop on the same edge with three entries stored.
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h60 + i));
        n = 0;
        while (!(m_phase == 0 && cyc >= m_allow) && n < 2000) begin
            tick(1'b0, 8'h00);
            n++;
        end
        if (n >= 2000) chk("t4_wait_timeout", 0, 1);
        chk("t4_cnt_before", int'(fifo_cnt), 3);
        tick(1'b1, 8'h64);
        chk("t4_cnt_after", int'(fifo_cnt), 3);
        drain_and_compare("t4");
        for (int i = 0; i < launched_q.size(); i++) chk("t4_order", launched_q[i], 8'h60 + i);
        chk("t4_launches", launched_q.size(), 5);
        clear_phase();

        // Two queued bytes: measure done -> next launch spacing.
        tick(1'b1, 8'hC1);
        tick(1'b1, 8'hC2);
        drain_and_compare("t5");
        chk("t5_gap_edges", gap_meas, GAP + 1);
        clear_phase();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)));
        end
        drain_and_compare("rnd");
        clear_phase();

        // Reset during the 4th data bit with five bytes still queued.
        do_reset("rst1");
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h70 + i));
        n = 0;
        while (!(tx_busy && tx_bit == 4) && n < 500) begin
            tick(1'b0, 8'h00);
            n++;
        end
        if (n >= 500) chk("t6_wait_timeout", 0, 1);
        chk("t6_queued", int'(fifo_cnt), 5);
        do_reset("t6rst");
        for (int i = 0; i < 60; i++) tick(1'b0, 8'h00);
        chk("t6_no_en", en_cnt, 0);
        tick(1'b1, 8'h5A);
        drain_and_compare("t6");
        chk("t6_launches", launched_q.size(), 1);
        if (launched_q.size() > 0) chk("t6_byte", launched_q[0], 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
